// File: rtl/aes_key_mem.sv
// AES round-key expander and 15-entry store: one round key per cycle, combinational read by round index.
// ready drops on init; entries written 2+i cycles after acceptance; ready returns after 12 (AES-128) or 16 (AES-256) cycles.
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128, then the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                 sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};
  end
endmodule

module aes_key_mem (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);
  localparam logic [1:0] CTRL_IDLE     = 2'd0;
  localparam logic [1:0] CTRL_INIT     = 2'd1;
  localparam logic [1:0] CTRL_GENERATE = 2'd2;

  logic [127:0] key_mem [0:14];
  logic [255:0] key_reg;
  logic         keylen_reg;
  logic [127:0] prev_key0;
  logic [127:0] prev_key1;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_ctr;
  logic         ready_reg;
  logic [1:0]   state;

  logic [3:0]   num_rounds;
  logic [7:0]   rcon_next;
  logic [31:0]  t;
  logic [31:0]  t_new;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         rcon_step;
  logic         from_key;
  logic [31:0]  k0, k1, k2, k3;
  logic [127:0] new_key;

  assign num_rounds = keylen_reg ? 4'd14 : 4'd10;
  assign rcon_next  = {rcon_reg[6:0], 1'b0} ^ (8'h1b & {8{rcon_reg[7]}});
  assign t          = prev_key1[31:0];
  // AES-256 alternates rcon (even) and plain SubWord (odd) rounds.
  assign rcon_step  = !keylen_reg || !round_ctr[0];
  assign from_key   = (round_ctr == 4'd0) || (keylen_reg && (round_ctr == 4'd1));
  assign sbox_in    = rcon_step ? {t[23:0], t[31:24]} : t;

  aes_sbox u_sbox (
    .sboxw     (sbox_in),
    .new_sboxw (sbox_out)
  );

  assign t_new = rcon_step ? (sbox_out ^ {rcon_next, 24'h0}) : sbox_out;
  assign k0    = prev_key0[127:96] ^ t_new;
  assign k1    = prev_key0[95:64]  ^ k0;
  assign k2    = prev_key0[63:32]  ^ k1;
  assign k3    = prev_key0[31:0]   ^ k2;

  always_comb begin
    new_key = {k0, k1, k2, k3};
    if (round_ctr == 4'd0)
      new_key = key_reg[255:128];
    else if (keylen_reg && (round_ctr == 4'd1))
      new_key = key_reg[127:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) key_mem[i] <= '0;
      key_reg    <= '0;
      keylen_reg <= 1'b0;
      prev_key0  <= '0;
      prev_key1  <= '0;
      rcon_reg   <= '0;
      round_ctr  <= '0;
      ready_reg  <= 1'b1;
      state      <= CTRL_IDLE;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (init) begin
            key_reg    <= key;
            keylen_reg <= keylen;
            ready_reg  <= 1'b0;
            state      <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          round_ctr <= 4'd0;
          rcon_reg  <= 8'h8d;
          state     <= CTRL_GENERATE;
        end
        CTRL_GENERATE: begin
          key_mem[round_ctr] <= new_key;
          prev_key1          <= new_key;
          prev_key0          <= keylen_reg ? prev_key1 : new_key;
          round_ctr          <= round_ctr + 4'd1;
          if (!from_key && rcon_step) rcon_reg <= rcon_next;
          if (round_ctr == num_rounds) begin
            ready_reg <= 1'b1;
            state     <= CTRL_IDLE;
          end
        end
        default: state <= CTRL_IDLE;
      endcase
    end
  end

  assign round_key = (round == 4'd15) ? 128'h0 : key_mem[round];
  assign ready     = ready_reg;
endmodule
